// File: rtl/arbiter_pkg.sv
// Shared arbiter definitions: mode encodings and the index-width helper.
// Intended to be reused by future multi-grant arbiter variants.
package arbiter_pkg;

  localparam int unsigned MODE_FIXED = 0;  // lowest index always wins
  localparam int unsigned MODE_RR    = 1;  // rotating-pointer round-robin

  // Width of a binary index into an n-entry vector; never narrower than 1 bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
//   req          requester -> arbiter  level request per requester
//   grant_ack    consumer  -> arbiter  accepts the presented grant
//   grant_valid  arbiter   -> consumer a grant is being presented
//   grant        arbiter   -> consumer one-hot grant (zero when not valid)
//   grant_idx    arbiter   -> consumer binary index of the grant bit
// Modports: slave = arbiter side, master = requester/consumer side.
interface rr_grant_arbiter_if
  import arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
);

  localparam int unsigned IDX_W = idx_w(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] req;
  logic                  grant_ack;
  logic                  grant_valid;
  logic [DATA_WIDTH-1:0] grant;
  logic [IDX_W-1:0]      grant_idx;

  modport slave (
    input  req,
    input  grant_ack,
    output grant_valid,
    output grant,
    output grant_idx
  );

  modport master (
    output req,
    output grant_ack,
    input  grant_valid,
    input  grant,
    input  grant_idx
  );

endinterface

// File: rtl/lsb_onehot_encoder.sv
// Combinational lowest-set-bit finder.
//   vec     input   vector to scan
//   onehot  output  one-hot of the lowest set bit (zero if vec is zero)
//   idx     output  binary index of that bit (zero if vec is zero)
//   any     output  vec has at least one bit set
module lsb_onehot_encoder
  import arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned IDX_W = idx_w(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] vec,
  output logic [DATA_WIDTH-1:0] onehot,
  output logic [IDX_W-1:0]      idx,
  output logic                  any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if (vec[i] && !any) begin
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered single-grant arbiter with fixed-priority or round-robin selection.
// A grant, once issued, is held frozen until grant_ack; on ack the next pick is
// made from the same cycle's req so back-to-back grants have no bubble.
//   clk    input  rising-edge clock
//   reset  input  synchronous, active-high
//   bus    slave  request/grant bundle (see rr_grant_arbiter_if)
module rr_grant_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MODE       = MODE_RR
) (
  input logic               clk,
  input logic               reset,
  rr_grant_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(DATA_WIDTH);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;

  logic                  ack_hold;
  logic [IDX_W-1:0]      ptr_inc;
  logic [IDX_W-1:0]      ptr_sel;
  logic [DATA_WIDTH-1:0] masked;

  logic [DATA_WIDTH-1:0] m_onehot, r_onehot, pick_onehot;
  logic [IDX_W-1:0]      m_idx, r_idx, pick_idx;
  logic                  m_any, r_any;

  assign ack_hold = (state_q == StHold) && bus.grant_ack;

  // Pointer moves just past the acknowledged grant; fixed mode pins it at 0.
  always_comb begin
    ptr_inc = '0;
    if (MODE == MODE_RR && grant_idx_q != IDX_W'(DATA_WIDTH - 1)) begin
      ptr_inc = grant_idx_q + IDX_W'(1);
    end
  end

  // The pick made on an ack must already see the updated pointer.
  assign ptr_sel = ack_hold ? ptr_inc : ptr_q;

  always_comb begin
    masked = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      masked[i] = bus.req[i] && (i >= int'(ptr_sel));
    end
  end

  lsb_onehot_encoder #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_enc_masked (
    .vec    (masked),
    .onehot (m_onehot),
    .idx    (m_idx),
    .any    (m_any)
  );

  lsb_onehot_encoder #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_enc_req (
    .vec    (bus.req),
    .onehot (r_onehot),
    .idx    (r_idx),
    .any    (r_any)
  );

  // Nothing at or above the pointer: wrap around to the lowest requester.
  assign pick_onehot = m_any ? m_onehot : r_onehot;
  assign pick_idx    = m_any ? m_idx    : r_idx;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (r_any) begin
          state_d     = StHold;
          grant_d     = pick_onehot;
          grant_idx_d = pick_idx;
        end else begin
          grant_d     = '0;
          grant_idx_d = '0;
        end
      end
      StHold: begin
        if (bus.grant_ack) begin
          ptr_d = ptr_inc;
          if (r_any) begin
            grant_d     = pick_onehot;
            grant_idx_d = pick_idx;
          end else begin
            state_d     = StIdle;
            grant_d     = '0;
            grant_idx_d = '0;
          end
        end
      end
      default: begin
        state_d     = StIdle;
        grant_d     = '0;
        grant_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.grant_valid = (state_q == StHold);
  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: a round-robin instance and a
// fixed-priority instance, both 4 requesters wide.
module tb_rr_grant_arbiter;
  import arbiter_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  rr_grant_arbiter_if #(.DATA_WIDTH(4)) rr_bus ();
  rr_grant_arbiter_if #(.DATA_WIDTH(4)) fx_bus ();

  rr_grant_arbiter #(
    .DATA_WIDTH (4),
    .MODE       (MODE_RR)
  ) dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (rr_bus.slave)
  );

  rr_grant_arbiter #(
    .DATA_WIDTH (4),
    .MODE       (MODE_FIXED)
  ) dut_fx (
    .clk   (clk),
    .reset (reset),
    .bus   (fx_bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rr(input string tag, input logic v, input logic [3:0] g,
                        input logic [1:0] idx);
    chk({tag, ".valid"}, 32'(rr_bus.grant_valid), 32'(v));
    chk({tag, ".grant"}, 32'(rr_bus.grant), 32'(g));
    chk({tag, ".idx"},   32'(rr_bus.grant_idx), 32'(idx));
  endtask

  task automatic chk_fx(input string tag, input logic v, input logic [3:0] g,
                        input logic [1:0] idx);
    chk({tag, ".valid"}, 32'(fx_bus.grant_valid), 32'(v));
    chk({tag, ".grant"}, 32'(fx_bus.grant), 32'(g));
    chk({tag, ".idx"},   32'(fx_bus.grant_idx), 32'(idx));
  endtask

  // Apply inputs, then sample 1 time unit after the next rising edge.
  task automatic step(input logic rst, input logic [3:0] r, input logic a);
    reset          = rst;
    rr_bus.req       = r;
    rr_bus.grant_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic step_fx(input logic [3:0] r, input logic a);
    fx_bus.req       = r;
    fx_bus.grant_ack = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    rr_bus.req = '0;
    rr_bus.grant_ack = 1'b0;
    fx_bus.req = '0;
    fx_bus.grant_ack = 1'b0;
    #1;

    // Reset held with all requests up.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b1111, 1'b0);
      chk_rr("reset", 1'b0, 4'b0000, 2'd0);
    end
    step(1'b0, 4'b1111, 1'b0);
    chk_rr("first_grant", 1'b1, 4'b0001, 2'd0);

    // Rotation with req=1011 and ack every cycle.
    step(1'b0, 4'b1011, 1'b1);
    chk_rr("rot1", 1'b1, 4'b0010, 2'd1);
    step(1'b0, 4'b1011, 1'b1);
    chk_rr("rot2", 1'b1, 4'b1000, 2'd3);
    step(1'b0, 4'b1011, 1'b1);
    chk_rr("rot3", 1'b1, 4'b0001, 2'd0);
    step(1'b0, 4'b1011, 1'b1);
    chk_rr("rot4", 1'b1, 4'b0010, 2'd1);

    // Hold: req changes, no ack, grant frozen.
    step(1'b0, 4'b0001, 1'b0);
    chk_rr("hold1", 1'b1, 4'b0010, 2'd1);
    step(1'b0, 4'b0000, 1'b0);
    chk_rr("hold2", 1'b1, 4'b0010, 2'd1);
    // Ack with ptr=2 and only bit 0 requesting: wrap fallback.
    step(1'b0, 4'b0001, 1'b1);
    chk_rr("wrap", 1'b1, 4'b0001, 2'd0);

    // Drain to idle.
    step(1'b0, 4'b0100, 1'b1);
    chk_rr("to_bit2", 1'b1, 4'b0100, 2'd2);
    step(1'b0, 4'b0000, 1'b1);
    chk_rr("drain", 1'b0, 4'b0000, 2'd0);
    step(1'b0, 4'b0000, 1'b1);
    chk_rr("idle_ack", 1'b0, 4'b0000, 2'd0);

    // Idle pick with ptr=3 wraps to bit 2; single requester re-granted on ack.
    step(1'b0, 4'b0100, 1'b0);
    chk_rr("idle_load", 1'b1, 4'b0100, 2'd2);
    step(1'b0, 4'b0100, 1'b1);
    chk_rr("regrant", 1'b1, 4'b0100, 2'd2);

    // Mid-hold reset: ptr must return to 0.
    step(1'b0, 4'b1000, 1'b1);
    chk_rr("to_bit3", 1'b1, 4'b1000, 2'd3);
    step(1'b1, 4'b1000, 1'b0);
    chk_rr("mid_reset", 1'b0, 4'b0000, 2'd0);
    step(1'b0, 4'b1001, 1'b0);
    chk_rr("post_reset", 1'b1, 4'b0001, 2'd0);

    // Fixed priority: bit 3 starved.
    step_fx(4'b1010, 1'b0);
    chk_fx("fx_load", 1'b1, 4'b0010, 2'd1);
    for (int i = 0; i < 3; i++) begin
      step_fx(4'b1010, 1'b1);
      chk_fx("fx_ack", 1'b1, 4'b0010, 2'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Registered, parametrised successor to the combinational lowest-bit sanitizer in the second-chance path. It takes a request vector from DATA_WIDTH table ways or requesters and issues exactly one one-hot grant, which it holds until acknowledged. A MODE parameter selects fixed lowest-index priority or round-robin with a rotating pointer. It sits between the per-way hit/free request logic and the single shared write/evict port.

## Interface
- DATA_WIDTH, 32: number of requesters; must be ≥ 1.
- MODE, 1: 0 = fixed priority (bit 0 highest); 1 = round-robin.
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- req  input  DATA_WIDTH  level request per requester; sampled every cycle.
- grant_ack  input  1  consumer accepts the current grant; meaningful only while grant_valid = 1.
- grant_valid  output  1  a grant is being presented.
- grant  output  DATA_WIDTH  one-hot grant; all-zero when grant_valid = 0.
- grant_idx  output  IDX_W  binary index of the grant bit; IDX_W = max(1, $clog2(DATA_WIDTH)).

## Operation
- State: one register each for grant_valid, grant, grant_idx and ptr (IDX_W bits). There are two states: IDLE (grant_valid = 0) and HOLD (grant_valid = 1).
- Candidate pick:
  - masked = req with bits below ptr cleared.
  - If masked ≠ 0, pick the lowest set bit of masked; otherwise pick the lowest set bit of req.
  - In MODE 0, ptr stays 0 at all times, so the pick is always the lowest set bit of req.
- IDLE: if req ≠ 0, load the pick and go to HOLD; otherwise stay in IDLE with grant = 0 and grant_idx = 0.
- HOLD, grant_ack = 0: grant and grant_idx stay frozen, even if req changes or the granted bit drops. The granted requester is committed once granted.
- HOLD, grant_ack = 1:
  - Set ptr = grant_idx + 1, wrapping to 0 when grant_idx = DATA_WIDTH−1 (MODE 1 only).
  - Compute the pick from the current-cycle req using the updated ptr.
  - If that pick is nonzero, stay in HOLD with the new grant; otherwise go to IDLE.
- grant_ack while in IDLE is ignored.
- Invariant: popcount(grant) = grant_valid. grant_idx always encodes grant when grant_valid = 1.
- DATA_WIDTH = 1: ptr is always 0 and grant = req registered, with hold/ack behaviour unchanged.

## Timing
- Reset values: grant_valid = 0, grant = 0, grant_idx = 0, ptr = 0. reset overrides everything in the same edge, including an in-flight HOLD; the grant is dropped without a pointer update.
- Request-to-grant latency: req rising in cycle t (IDLE) gives grant_valid = 1 in cycle t+1.
- Back-to-back throughput: grant_ack in cycle t with other requests pending gives the next grant in cycle t+1, with no bubble. Sustained rate is one grant per cycle.
- A single persistent requester with ack every cycle is re-granted every cycle.
- Outputs are purely registered; there is no combinational path from req or grant_ack to any output.

## Structure
- Shared package arbiter_pkg: MODE_FIXED = 0, MODE_RR = 1, and the IDX_W width function. Reuse it for future multi-grant variants.
- One sub-module, lsb_onehot_encoder (parameter DATA_WIDTH):
  - Combinational; takes a vector and produces its lowest-set-bit one-hot, binary index and any flag.
  - Instantiated twice: once for masked, once for unmasked req.
- Top level: the mask generator, select mux, ptr update and output registers.

## Test plan
All scenarios use DATA_WIDTH = 4, MODE = 1 unless stated.
- Reset: hold reset 3 cycles with req = 4'b1111 → grant_valid = 0, grant = 0, grant_idx = 0 throughout; grant = 4'b0001 one cycle after reset deasserts.
- Round-robin rotation: req = 4'b1011 held, ack every cycle → grant sequence 0001, 0010, 1000, 0001, with grant_idx 0, 1, 3, 0.
- Hold: grant = 4'b0010, no ack, req changes to 4'b0001 → grant stays 4'b0010 until ack. After ack, the next grant is 4'b0001 (wrap fallback to the unmasked pick).
- Ack drains to idle: req = 4'b0100 only, ack in cycle t, req = 0 in cycle t → grant_valid = 0 and grant = 0 at t+1; ack while idle has no effect.
- Fixed mode (MODE = 0): req = 4'b1010 held, ack every cycle → grant = 4'b0010 every cycle; bit 3 is starved.
- Mid-hold reset: grant = 4'b1000 held, reset for 1 cycle → outputs zero. The next grant with req = 4'b1001 is 4'b0001, confirming ptr reset to 0.
